// File: rtl/la_iopwrseq.sv
// IO-ring power sequencer: enables ring segments one at a time, ascending on power-up and descending on power-down.
// Latency: SETTLE+1 cycles per segment step when supply-good is already present. All outputs are registered.
// Flow control: none. pwr_req is level-sensitive. A missing stage_good stalls power-up until TIMEOUT, then FAULT.
//
// Ports:
//   clk         sequencer clock
//   nreset      asynchronous active-low reset
//   pwr_req     1 = ring requested on, 0 = ring requested off
//   stage_good  per-segment supply-good, synchronous to clk
//   ioring_en   per-segment enables onto the ioring control bits (always a thermometer mask)
//   pwr_ready   all segments enabled and good (state ON)
//   busy        sequencing in progress (UP_WAIT / DOWN_WAIT)
//   error       sequencing fault latched (state FAULT)
//   stage       index of the segment currently being sequenced
//
// Optional macro LA_IOPWRSEQ_MONITOR_EN: while ON with pwr_req=1, any stage_good bit low forces FAULT.

module la_iopwrseq #(
    parameter int RINGW   = 8,
    parameter int SETTLE  = 16,
    parameter int TIMEOUT = 1024,
    localparam int CW     = $clog2(TIMEOUT + 1),
    localparam int IW     = (RINGW > 1) ? $clog2(RINGW) : 1
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             pwr_req,
    input  logic [RINGW-1:0] stage_good,
    output logic [RINGW-1:0] ioring_en,
    output logic             pwr_ready,
    output logic             busy,
    output logic             error,
    output logic [IW-1:0]    stage
);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_UP_WAIT   = 3'd1,
        S_ON        = 3'd2,
        S_DOWN_WAIT = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    localparam logic [IW-1:0] LAST_STAGE = IW'(RINGW - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [RINGW-1:0] r_en;
    logic [IW-1:0]    r_stage;
    logic             r_ready;
    logic             r_busy;
    logic             r_error;

    logic [CW-1:0]    w_cnt_inc;
    logic [IW-1:0]    w_stage_inc;
    logic [IW-1:0]    w_stage_dec;

    // Counter saturates so a stuck state can never wrap back below SETTLE.
    assign w_cnt_inc   = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);
    assign w_stage_inc = r_stage + IW'(1);
    assign w_stage_dec = r_stage - IW'(1);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            r_en    <= '0;
            r_stage <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                S_OFF: begin
                    if (pwr_req) begin
                        r_en[0] <= 1'b1;
                        r_stage <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_UP_WAIT;
                    end
                end

                S_UP_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (!pwr_req) begin
                        // Abort: retract the segment in progress, then unwind from here.
                        r_en[r_stage] <= 1'b0;
                        r_cnt         <= '0;
                        r_state       <= S_DOWN_WAIT;
                    end else if (r_cnt >= CW'(SETTLE) && stage_good[r_stage]) begin
                        r_cnt <= '0;
                        if (r_stage == LAST_STAGE) begin
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                            r_state <= S_ON;
                        end else begin
                            r_stage           <= w_stage_inc;
                            r_en[w_stage_inc] <= 1'b1;
                        end
                    end else if (r_cnt == CW'(TIMEOUT)) begin
                        // Stage index is kept so software can see which segment failed.
                        r_en    <= '0;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                        r_state <= S_FAULT;
                    end
                end

                S_ON: begin
                    if (!pwr_req) begin
                        r_en[RINGW-1] <= 1'b0;
                        r_cnt         <= '0;
                        r_ready       <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= S_DOWN_WAIT;
                    end
`ifdef LA_IOPWRSEQ_MONITOR_EN
                    else if (!(&stage_good)) begin
                        r_en    <= '0;
                        r_stage <= '0;
                        r_ready <= 1'b0;
                        r_error <= 1'b1;
                        r_state <= S_FAULT;
                    end
`endif
                end

                S_DOWN_WAIT: begin
                    // pwr_req and stage_good are deliberately ignored until OFF.
                    r_cnt <= w_cnt_inc;
                    if (r_cnt == CW'(SETTLE)) begin
                        r_cnt <= '0;
                        if (r_stage == '0) begin
                            r_busy  <= 1'b0;
                            r_state <= S_OFF;
                        end else begin
                            r_stage           <= w_stage_dec;
                            r_en[w_stage_dec] <= 1'b0;
                        end
                    end
                end

                S_FAULT: begin
                    if (!pwr_req) begin
                        r_error <= 1'b0;
                        r_state <= S_OFF;
                    end
                end

                default: begin
                    r_en    <= '0;
                    r_cnt   <= '0;
                    r_stage <= '0;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_error <= 1'b0;
                    r_state <= S_OFF;
                end
            endcase
        end
    end

    assign ioring_en = r_en;
    assign pwr_ready = r_ready;
    assign busy      = r_busy;
    assign error     = r_error;
    assign stage     = r_stage;

endmodule

// File: tb/tb_la_iopwrseq.sv
// Bench for la_iopwrseq with RINGW=4, SETTLE=4, TIMEOUT=20.
// Stimulus pushes expected outputs keyed by clock-edge number; a monitor pops and compares #1 after each edge.
// Expectations follow the LA_IOPWRSEQ_MONITOR_EN setting used for the build.

module tb_la_iopwrseq;

    localparam int RINGW   = 4;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 20;

    typedef struct {
        int         cyc;
        logic [3:0] en;
        logic       rdy;
        logic       bsy;
        logic       err;
        logic [1:0] st;
        bit         chk_st;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       nreset;
    logic       pwr_req;
    logic [3:0] stage_good;
    logic [3:0] ioring_en;
    logic       pwr_ready;
    logic       busy;
    logic       error;
    logic [1:0] stage;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    la_iopwrseq #(
        .RINGW   (RINGW),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .pwr_req    (pwr_req),
        .stage_good (stage_good),
        .ioring_en  (ioring_en),
        .pwr_ready  (pwr_ready),
        .busy       (busy),
        .error      (error),
        .stage      (stage)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string n, input logic [3:0] en, input logic rdy, input logic bsy,
                         input logic err, input logic [1:0] st, input bit chk_st);
        checks++;
        if (ioring_en !== en || pwr_ready !== rdy || busy !== bsy || error !== err ||
            (chk_st && stage !== st)) begin
            errors++;
            $display("FAIL %s @cyc %0d: got en=%b rdy=%b busy=%b err=%b stage=%0d, want en=%b rdy=%b busy=%b err=%b stage=%0d%s",
                     n, cyc, ioring_en, pwr_ready, busy, error, stage, en, rdy, bsy, err, st,
                     chk_st ? "" : "(unchecked)");
        end
    endtask

    task automatic expect_at(input int c, input logic [3:0] en, input logic rdy, input logic bsy,
                             input logic err, input logic [1:0] st, input bit chk_st, input string n);
        exp_t e;
        e.cyc = c; e.en = en; e.rdy = rdy; e.bsy = bsy; e.err = err;
        e.st = st; e.chk_st = chk_st; e.name = n;
        q.push_back(e);
    endtask

    // Wait until the negedge that follows edge c; inputs set here are sampled at edge c+1.
    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: compare every expectation registered for the edge that just occurred.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: expectation for cyc %0d not checked in time (now %0d)", e.name, e.cyc, cyc);
            end else begin
                check(e.name, e.en, e.rdy, e.bsy, e.err, e.st, e.chk_st);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int k, m, k2, a, t, k3, k4, r;
        nreset     = 1'b0;
        pwr_req    = 1'b0;
        stage_good = 4'b1111;
        #1;
        check("reset_init", 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        at(2);
        nreset = 1'b1;

        // Power-up with all segments good.
        at(4);
        k = cyc + 1;
        expect_at(k,      4'b0001, 0, 1, 0, 2'd0, 1, "up_k");
        expect_at(k + 4,  4'b0001, 0, 1, 0, 2'd0, 1, "up_k4_hold");
        expect_at(k + 5,  4'b0011, 0, 1, 0, 2'd1, 1, "up_k5");
        expect_at(k + 10, 4'b0111, 0, 1, 0, 2'd2, 1, "up_k10");
        expect_at(k + 15, 4'b1111, 0, 1, 0, 2'd3, 1, "up_k15");
        expect_at(k + 19, 4'b1111, 0, 1, 0, 2'd3, 1, "up_k19");
        expect_at(k + 20, 4'b1111, 1, 0, 0, 2'd3, 1, "up_ready");
        pwr_req = 1'b1;

        // Power-down from ON.
        at(k + 21);
        m = cyc + 1;
        expect_at(m,      4'b0111, 0, 1, 0, 2'd3, 1, "dn_m");
        expect_at(m + 4,  4'b0111, 0, 1, 0, 2'd3, 1, "dn_m4_hold");
        expect_at(m + 5,  4'b0011, 0, 1, 0, 2'd2, 1, "dn_m5");
        expect_at(m + 10, 4'b0001, 0, 1, 0, 2'd1, 1, "dn_m10");
        expect_at(m + 15, 4'b0000, 0, 1, 0, 2'd0, 1, "dn_m15");
        expect_at(m + 19, 4'b0000, 0, 1, 0, 2'd0, 1, "dn_m19");
        expect_at(m + 20, 4'b0000, 0, 0, 0, 2'd0, 1, "dn_off");
        pwr_req = 1'b0;

        // Abort during stage 1, re-request ignored until OFF.
        at(m + 21);
        k2 = cyc + 1;
        expect_at(k2,     4'b0001, 0, 1, 0, 2'd0, 1, "ab_up0");
        expect_at(k2 + 5, 4'b0011, 0, 1, 0, 2'd1, 1, "ab_up1");
        pwr_req = 1'b1;
        at(k2 + 7);
        a = cyc + 1;
        expect_at(a,      4'b0001, 0, 1, 0, 2'd1, 1, "ab_a");
        expect_at(a + 4,  4'b0001, 0, 1, 0, 2'd1, 1, "ab_a4_ignore_req");
        expect_at(a + 5,  4'b0000, 0, 1, 0, 2'd0, 1, "ab_a5");
        expect_at(a + 10, 4'b0000, 0, 0, 0, 2'd0, 1, "ab_off");
        expect_at(a + 11, 4'b0001, 0, 1, 0, 2'd0, 1, "ab_restart");
        expect_at(a + 31, 4'b1111, 1, 0, 0, 2'd3, 1, "ab_ready");
        pwr_req = 1'b0;
        at(a + 2);
        pwr_req = 1'b1;

        // One-cycle supply-good drop while ON.
        at(a + 32);
        t = cyc + 1;
`ifdef LA_IOPWRSEQ_MONITOR_EN
        expect_at(t,     4'b0000, 0, 0, 1, 2'd0, 1, "mon_fault");
        expect_at(t + 1, 4'b0000, 0, 0, 1, 2'd0, 1, "mon_fault_hold");
        expect_at(t + 2, 4'b0000, 0, 0, 0, 2'd0, 1, "mon_clear");
`else
        expect_at(t,     4'b1111, 1, 0, 0, 2'd3, 1, "mon_ignored");
        expect_at(t + 1, 4'b1111, 1, 0, 0, 2'd3, 1, "mon_ignored_hold");
        expect_at(t + 2, 4'b0111, 0, 1, 0, 2'd3, 1, "mon_powerdown");
`endif
        stage_good = 4'b1110;
        at(t);
        stage_good = 4'b1111;
        at(t + 1);
        pwr_req = 1'b0;

        // Timeout on stage 2, then clear the fault.
        at(t + 25);
        stage_good = 4'b0011;
        k3 = cyc + 1;
        expect_at(k3 + 5,  4'b0011, 0, 1, 0, 2'd1, 1, "to_stage1");
        expect_at(k3 + 10, 4'b0111, 0, 1, 0, 2'd2, 1, "to_stage2");
        expect_at(k3 + 30, 4'b0111, 0, 1, 0, 2'd2, 1, "to_cnt20");
        expect_at(k3 + 31, 4'b0000, 0, 0, 1, 2'd2, 1, "to_fault");
        expect_at(k3 + 32, 4'b0000, 0, 0, 1, 2'd2, 1, "to_fault_hold");
        expect_at(k3 + 33, 4'b0000, 0, 0, 0, 2'd0, 0, "to_clear");
        pwr_req = 1'b1;
        at(k3 + 32);
        pwr_req = 1'b0;

        // Asynchronous reset mid-sequence.
        at(k3 + 35);
        stage_good = 4'b1111;
        k4 = cyc + 1;
        expect_at(k4 + 5, 4'b0011, 0, 1, 0, 2'd1, 1, "rst_pre");
        pwr_req = 1'b1;
        at(k4 + 6);
        nreset = 1'b0;
        #1;
        check("rst_async", 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        pwr_req = 1'b0;
        at(k4 + 8);
        nreset = 1'b1;
        r = cyc;
        expect_at(r + 1, 4'b0000, 0, 0, 0, 2'd0, 1, "rst_off1");
        expect_at(r + 3, 4'b0000, 0, 0, 0, 2'd0, 1, "rst_off3");
        expect_at(r + 4, 4'b0001, 0, 1, 0, 2'd0, 1, "rst_restart");
        at(r + 3);
        pwr_req = 1'b1;
        at(r + 6);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations never checked", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
